self_dete_table: RTL

Reflection table that sits directly downstream of the self-detection stage. During self-detection it captures each 16-bit reflection word {action, aicou, sensor, stray_station} and keeps, per action, the entry with the smallest current (aicou) that moved the tray. After detection finishes it answers lookups from the motion controller with the minimum force per action, using a fixed-latency serial scan.

---
 rtl/self_dete_table_if.sv | 30 +++
 rtl/self_dete_table.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/self_dete_table_if.sv
// self_dete_table_if: bundles the self-detection table control, write and lookup signals.
// master drives enable/finish, the write channel and lookup requests; slave is the table.
interface self_dete_table_if #(parameter int AW = 2);
   logic          self_detection_enable;
   logic          fi_self_dete;
   logic          wr_valid;
   logic [15:0]   wr_entry;
   logic          wr_ready;
   logic          rd_req;
   logic [1:0]    rd_action;
   logic          rd_ready;
   logic          rd_valid;
   logic          rd_hit;
   logic [3:0]    rd_aicou;
   logic [1:0]    rd_sensor;
   logic [7:0]    rd_station;
   logic          table_ready;
   logic [AW:0]   entry_count;
   logic          overflow;
   modport master (
      output self_detection_enable, fi_self_dete, wr_valid, wr_entry, rd_req, rd_action,
      input  wr_ready, rd_ready, rd_valid, rd_hit, rd_aicou, rd_sensor, rd_station,
             table_ready, entry_count, overflow
   );
   modport slave (
      input  self_detection_enable, fi_self_dete, wr_valid, wr_entry, rd_req, rd_action,
      output wr_ready, rd_ready, rd_valid, rd_hit, rd_aicou, rd_sensor, rd_station,
             table_ready, entry_count, overflow
   );
endinterface

// File: rtl/self_dete_table.sv
// self_dete_table: keeps the minimum-aicou reflection word per action during self-detection
// and answers per-action lookups with a fixed-latency serial scan afterwards.
// Ports: clk, rst (sync, active high); bus.slave carries enable/finish, the write channel
// (wr_valid/wr_entry/wr_ready), the lookup channel (rd_req/rd_action/rd_ready and the
// rd_valid result strobe with rd_hit/rd_aicou/rd_sensor/rd_station) and status
// (table_ready, entry_count, overflow).
module self_dete_table #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic             clk,
   input logic             rst,
   self_dete_table_if.slave bus
);
   typedef enum logic [2:0] {IDLE, COLLECT, MERGE, READY, SCAN} state_t;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   state_t            state_q, state_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [15:0]       ent_q [DEPTH];
   logic [15:0]       ent_d [DEPTH];
   logic [AW:0]       cnt_q, cnt_d, sidx_q, sidx_d;
   logic [15:0]       word_q, word_d;
   logic [13:0]       fent_q, fent_d, res_q, res_d;
   logic [1:0]        ract_q, ract_d;
   logic              ovf_q, ovf_d, fi_q, fi_d, fhit_q, fhit_d, hit_q, hit_d;
   logic              rd_valid_q, rd_valid_d, rd_ready_q, rd_ready_d;
   logic              wr_ready_q, wr_ready_d, table_ready_q, table_ready_d;
   logic              hit_m, legal;
   logic [AW-1:0]     idx_m;
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      ent_d      = ent_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      word_d     = word_q;
      fi_d       = fi_q;
      ract_d     = ract_q;
      sidx_d     = sidx_q;
      fhit_d     = fhit_q;
      fent_d     = fent_q;
      hit_d      = hit_q;
      res_d      = res_q;
      rd_valid_d = 1'b0;
      hit_m      = 1'b0;
      idx_m      = '0;
      // actions are unique in the table, so at most one entry can match the latched word
      for (int i = 0; i < DEPTH; i++)
         if (valid_q[i] && ent_q[i][15:14] == word_q[15:14]) begin
            hit_m = 1'b1;
            idx_m = AW'(i);
         end
      legal = word_q[9:8] != 2'b00 && (word_q[15:14] == 2'b01 || word_q[15:14] == 2'b10);
      if (bus.self_detection_enable) begin
         state_d = COLLECT;
         valid_d = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         fi_d    = 1'b0;
         hit_d   = 1'b0;
         res_d   = '0;
      end else begin
         case (state_q)
            COLLECT:
               if (bus.wr_valid) begin
                  word_d  = bus.wr_entry;
                  fi_d    = fi_q | bus.fi_self_dete;
                  state_d = MERGE;
               end else if (bus.fi_self_dete) state_d = READY;
            MERGE: begin
               state_d = (fi_q || bus.fi_self_dete) ? READY : COLLECT;
               if (legal && hit_m) begin
                  if (word_q[13:10] < ent_q[idx_m][13:10]) ent_d[idx_m] = word_q;
               end else if (legal && cnt_q < FULL) begin
                  ent_d[cnt_q[AW-1:0]]   = word_q;
                  valid_d[cnt_q[AW-1:0]] = 1'b1;
                  cnt_d                  = cnt_q + (AW+1)'(1);
               end else if (legal) ovf_d = 1'b1;
            end
            READY:
               if (bus.rd_req && rd_ready_q) begin
                  ract_d  = bus.rd_action;
                  sidx_d  = '0;
                  fhit_d  = 1'b0;
                  fent_d  = '0;
                  state_d = SCAN;
               end
            SCAN:
               // DEPTH visit cycles, then one cycle to publish the result
               if (sidx_q < FULL) begin
                  if (!fhit_q && valid_q[sidx_q[AW-1:0]] && ent_q[sidx_q[AW-1:0]][15:14] == ract_q) begin
                     fhit_d = 1'b1;
                     fent_d = ent_q[sidx_q[AW-1:0]][13:0];
                  end
                  sidx_d = sidx_q + (AW+1)'(1);
               end else begin
                  rd_valid_d = 1'b1;
                  hit_d      = fhit_q;
                  res_d      = fent_q;
                  state_d    = READY;
               end
            default: ;
         endcase
      end
      wr_ready_d    = state_d == COLLECT;
      table_ready_d = state_d == READY;
      rd_ready_d    = state_d == READY && !rd_valid_d;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q       <= IDLE;
         valid_q       <= '0;
         ent_q         <= '{default: '0};
         cnt_q         <= '0;
         ovf_q         <= 1'b0;
         word_q        <= '0;
         fi_q          <= 1'b0;
         ract_q        <= '0;
         sidx_q        <= '0;
         fhit_q        <= 1'b0;
         fent_q        <= '0;
         hit_q         <= 1'b0;
         res_q         <= '0;
         rd_valid_q    <= 1'b0;
         rd_ready_q    <= 1'b0;
         wr_ready_q    <= 1'b0;
         table_ready_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         ent_q         <= ent_d;
         cnt_q         <= cnt_d;
         ovf_q         <= ovf_d;
         word_q        <= word_d;
         fi_q          <= fi_d;
         ract_q        <= ract_d;
         sidx_q        <= sidx_d;
         fhit_q        <= fhit_d;
         fent_q        <= fent_d;
         hit_q         <= hit_d;
         res_q         <= res_d;
         rd_valid_q    <= rd_valid_d;
         rd_ready_q    <= rd_ready_d;
         wr_ready_q    <= wr_ready_d;
         table_ready_q <= table_ready_d;
      end
   assign bus.wr_ready    = wr_ready_q;
   assign bus.rd_ready    = rd_ready_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_hit      = hit_q;
   assign bus.rd_aicou    = res_q[13:10];
   assign bus.rd_sensor   = res_q[9:8];
   assign bus.rd_station  = res_q[7:0];
   assign bus.table_ready = table_ready_q;
   assign bus.entry_count = cnt_q;
   assign bus.overflow    = ovf_q;
endmodule
